// File: rtl/dm_pkg.sv
// Shared constants, grant encoding and address masking for the data-memory arbiter.
package dm_pkg;

  localparam int DM_ADDR_W = 10;
  localparam int DM_DEPTH  = 1024;
  localparam int DM_DATA_W = 32;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_LD   = 2'd1,
    GNT_ST   = 2'd2
  } gnt_e;

  // Keep the low `width` bits of a word address; everything above reads as zero.
  function automatic logic [31:0] dm_mask_addr(input logic [31:0] addr,
                                               input int width = DM_ADDR_W);
    logic [31:0] res;
    res = 32'd0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) begin
        res[i] = addr[i];
      end else begin
        res[i] = 1'b0;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// Load/store request, load response and memory-side bus of the data-memory arbiter.
interface dm_arbiter_if
  import dm_pkg::*;
#(
  parameter int TAG_W = 4
);
  logic                 flush;
  logic                 ld_req_valid;
  logic [31:0]          ld_req_addr;
  logic [TAG_W-1:0]     ld_req_tag;
  logic                 ld_req_ready;
  logic                 ld_resp_valid;
  logic [TAG_W-1:0]     ld_resp_tag;
  logic [DM_DATA_W-1:0] ld_resp_data;
  logic                 st_req_valid;
  logic [31:0]          st_req_addr;
  logic [DM_DATA_W-1:0] st_req_data;
  logic                 st_req_ready;
  logic [31:0]          dm_address;
  logic [DM_DATA_W-1:0] dm_data;
  logic                 dm_rden;
  logic                 dm_wren;
  logic [DM_DATA_W-1:0] dm_q;

  // Core pipeline and memory side.
  modport master (
    output flush, ld_req_valid, ld_req_addr, ld_req_tag,
    output st_req_valid, st_req_addr, st_req_data, dm_q,
    input  ld_req_ready, ld_resp_valid, ld_resp_tag, ld_resp_data,
    input  st_req_ready, dm_address, dm_data, dm_rden, dm_wren
  );

  // Arbiter side.
  modport slave (
    input  flush, ld_req_valid, ld_req_addr, ld_req_tag,
    input  st_req_valid, st_req_addr, st_req_data, dm_q,
    output ld_req_ready, ld_resp_valid, ld_resp_tag, ld_resp_data,
    output st_req_ready, dm_address, dm_data, dm_rden, dm_wren
  );

endinterface

// File: rtl/dm_grant_fsm.sv
// Store-priority grant decision with a saturating streak counter that bounds load starvation.
module dm_grant_fsm #(
  parameter int ST_BURST_MAX = 4
) (
  input  logic clock,
  input  logic rst,
  input  logic ld_elig,
  input  logic st_elig,
  output logic gnt_ld,
  output logic gnt_st
);

  localparam int CNT_W = $clog2(ST_BURST_MAX + 1);
  localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(ST_BURST_MAX);

  logic [CNT_W-1:0] streak_r;
  logic             ld_turn_s;

  // A waiting load takes the port once stores have held it for ST_BURST_MAX cycles.
  always_comb begin
    gnt_ld    = 1'b0;
    gnt_st    = 1'b0;
    ld_turn_s = ld_elig && (streak_r == STREAK_MAX);
    if (st_elig && !ld_turn_s) begin
      gnt_st = 1'b1;
    end else if (ld_elig) begin
      gnt_ld = 1'b1;
    end else begin
      gnt_ld = 1'b0;
      gnt_st = 1'b0;
    end
  end

  // Streak only counts stores that actually made a load wait.
  always_ff @(posedge clock) begin
    if (rst) begin
      streak_r <= {CNT_W{1'b0}};
    end else if (!ld_elig || gnt_ld) begin
      streak_r <= {CNT_W{1'b0}};
    end else if (gnt_st && (streak_r != STREAK_MAX)) begin
      streak_r <= streak_r + CNT_W'(1);
    end else begin
      streak_r <= streak_r;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Shares the single-port data memory between the load unit and store commit;
// load data comes back one cycle after grant, tagged and squashable by flush.
module dm_arbiter
  import dm_pkg::*;
#(
  parameter int ADDR_W       = DM_ADDR_W,
  parameter int TAG_W        = 4,
  parameter int ST_BURST_MAX = 4
) (
  input  logic         clock,
  input  logic         rst,
  dm_arbiter_if.slave  bus
);

  logic             ld_elig_s;
  logic             st_elig_s;
  logic             gnt_ld_s;
  logic             gnt_st_s;
  gnt_e             gnt_s;
  logic             pending_r;
  logic [TAG_W-1:0] tag_r;

  assign ld_elig_s = bus.ld_req_valid && !bus.flush && !rst;
  assign st_elig_s = bus.st_req_valid && !rst;

  dm_grant_fsm #(
    .ST_BURST_MAX (ST_BURST_MAX)
  ) u_grant (
    .clock   (clock),
    .rst     (rst),
    .ld_elig (ld_elig_s),
    .st_elig (st_elig_s),
    .gnt_ld  (gnt_ld_s),
    .gnt_st  (gnt_st_s)
  );

  assign bus.ld_req_ready = gnt_ld_s;
  assign bus.st_req_ready = gnt_st_s;

  // Memory port mux; at most one of rden/wren by construction of gnt_s.
  always_comb begin
    gnt_s          = GNT_NONE;
    bus.dm_rden    = 1'b0;
    bus.dm_wren    = 1'b0;
    bus.dm_address = 32'd0;
    bus.dm_data    = {DM_DATA_W{1'b0}};
    if (gnt_st_s) begin
      gnt_s = GNT_ST;
    end else if (gnt_ld_s) begin
      gnt_s = GNT_LD;
    end else begin
      gnt_s = GNT_NONE;
    end
    case (gnt_s)
      GNT_ST: begin
        bus.dm_wren    = 1'b1;
        bus.dm_address = dm_mask_addr(bus.st_req_addr, ADDR_W);
        bus.dm_data    = bus.st_req_data;
      end
      GNT_LD: begin
        bus.dm_rden    = 1'b1;
        bus.dm_address = dm_mask_addr(bus.ld_req_addr, ADDR_W);
      end
      default: begin
        bus.dm_rden    = 1'b0;
        bus.dm_wren    = 1'b0;
        bus.dm_address = 32'd0;
        bus.dm_data    = {DM_DATA_W{1'b0}};
      end
    endcase
  end

  // Track the single in-flight load so its tag lines up with the memory's registered q.
  always_ff @(posedge clock) begin
    if (rst) begin
      pending_r <= 1'b0;
      tag_r     <= {TAG_W{1'b0}};
    end else if (gnt_ld_s) begin
      pending_r <= 1'b1;
      tag_r     <= bus.ld_req_tag;
    end else begin
      pending_r <= 1'b0;
      tag_r     <= tag_r;
    end
  end

  assign bus.ld_resp_valid = pending_r && !bus.flush && !rst;
  assign bus.ld_resp_tag   = tag_r;
  assign bus.ld_resp_data  = bus.dm_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed vector bench for dm_arbiter with a 1024x32 synchronous-read memory model.
module tb_dm_arbiter;
  import dm_pkg::*;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  logic mem_init = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  logic [31:0] mem [DM_DEPTH];

  dm_arbiter_if #(.TAG_W(4)) bus ();

  dm_arbiter #(.ADDR_W(10), .TAG_W(4), .ST_BURST_MAX(4)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < DM_DEPTH; i++) mem[i] <= 32'd0;
      mem[1] <= 32'd10;
      mem[2] <= 32'd20;
      mem[3] <= 32'd30;
      bus.dm_q <= 32'd0;
    end else begin
      if (bus.dm_wren) mem[bus.dm_address[9:0]] <= bus.dm_data;
      if (bus.dm_rden) bus.dm_q <= mem[bus.dm_address[9:0]];
    end
  end

  typedef struct {
    logic        rst, flush, lv;
    logic [31:0] la;
    logic [3:0]  lt;
    logic        sv;
    logic [31:0] sa, sd;
    logic        lr, sr, rd, wr;
    logic [31:0] addr, data;
    logic        rv;
    logic [3:0]  rt;
    logic        chk_rt;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic f, input logic lv, input logic [31:0] la,
                     input logic [3:0] lt, input logic sv, input logic [31:0] sa,
                     input logic [31:0] sd, input logic lr, input logic sr, input logic rd,
                     input logic wr, input logic [31:0] addr, input logic [31:0] data,
                     input logic rv, input logic [3:0] rt, input logic chk_rt,
                     input logic [31:0] rdata);
    vec_t v;
    v.rst = r; v.flush = f; v.lv = lv; v.la = la; v.lt = lt; v.sv = sv; v.sa = sa; v.sd = sd;
    v.lr = lr; v.sr = sr; v.rd = rd; v.wr = wr; v.addr = addr; v.data = data;
    v.rv = rv; v.rt = rt; v.chk_rt = chk_rt; v.rdata = rdata;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic lv, input logic [31:0] la,
                       input logic [3:0] lt, input logic sv, input logic [31:0] sa,
                       input logic [31:0] sd);
    @(negedge clock);
    rst = r; bus.flush = f;
    bus.ld_req_valid = lv; bus.ld_req_addr = la; bus.ld_req_tag = lt;
    bus.st_req_valid = sv; bus.st_req_addr = sa; bus.st_req_data = sd;
    #1;
  endtask

  initial begin
    string pat;
    logic  prev_l;
    logic  exp_s;

    //  rst f lv la            lt  sv sa            sd         lr sr rd wr addr   data       rv rt ck rdata
    add(1, 0, 1, 32'd7,        5, 1, 32'd9,        32'd1,     0, 0, 0, 0, 32'd0, 32'd0,     0, 0, 1, 32'd0);
    add(0, 0, 0, 32'd0,        0, 1, 32'd5,        32'hDEAD,  0, 1, 0, 1, 32'd5, 32'hDEAD,  0, 0, 1, 32'd0);
    add(0, 0, 1, 32'd5,        3, 0, 32'd0,        32'd0,     1, 0, 1, 0, 32'd5, 32'd0,     0, 0, 0, 32'd0);
    add(0, 0, 0, 32'd0,        0, 0, 32'd0,        32'd0,     0, 0, 0, 0, 32'd0, 32'd0,     1, 3, 0, 32'hDEAD);
    add(0, 0, 0, 32'd0,        0, 1, 32'h405,      32'd7,     0, 1, 0, 1, 32'd5, 32'd7,     0, 0, 0, 32'd0);
    add(0, 0, 1, 32'd5,        6, 0, 32'd0,        32'd0,     1, 0, 1, 0, 32'd5, 32'd0,     0, 0, 0, 32'd0);
    add(0, 0, 0, 32'd0,        0, 0, 32'd0,        32'd0,     0, 0, 0, 0, 32'd0, 32'd0,     1, 6, 0, 32'd7);
    add(0, 0, 1, 32'd1,        1, 0, 32'd0,        32'd0,     1, 0, 1, 0, 32'd1, 32'd0,     0, 0, 0, 32'd0);
    add(0, 0, 1, 32'd2,        2, 0, 32'd0,        32'd0,     1, 0, 1, 0, 32'd2, 32'd0,     1, 1, 0, 32'd10);
    add(0, 0, 1, 32'd3,        3, 0, 32'd0,        32'd0,     1, 0, 1, 0, 32'd3, 32'd0,     1, 2, 0, 32'd20);
    add(0, 0, 0, 32'd0,        0, 0, 32'd0,        32'd0,     0, 0, 0, 0, 32'd0, 32'd0,     1, 3, 0, 32'd30);
    add(0, 0, 1, 32'd2,        2, 0, 32'd0,        32'd0,     1, 0, 1, 0, 32'd2, 32'd0,     0, 0, 0, 32'd0);
    add(0, 1, 1, 32'd3,        4, 1, 32'd8,        32'h55,    0, 1, 0, 1, 32'd8, 32'h55,    0, 0, 0, 32'd0);
    add(0, 0, 0, 32'd0,        0, 0, 32'd0,        32'd0,     0, 0, 0, 0, 32'd0, 32'd0,     0, 0, 0, 32'd0);
    add(0, 1, 1, 32'd4,        1, 0, 32'd0,        32'd0,     0, 0, 0, 0, 32'd0, 32'd0,     0, 0, 0, 32'd0);
    add(0, 0, 1, 32'd1,        9, 0, 32'd0,        32'd0,     1, 0, 1, 0, 32'd1, 32'd0,     0, 0, 0, 32'd0);
    add(1, 0, 1, 32'd2,        4, 1, 32'd3,        32'd9,     0, 0, 0, 0, 32'd0, 32'd0,     0, 0, 0, 32'd0);
    add(0, 0, 0, 32'd0,        0, 0, 32'd0,        32'd0,     0, 0, 0, 0, 32'd0, 32'd0,     0, 0, 1, 32'd0);
    add(0, 0, 1, 32'd8,        7, 0, 32'd0,        32'd0,     1, 0, 1, 0, 32'd8, 32'd0,     0, 0, 0, 32'd0);
    add(0, 0, 0, 32'd0,        0, 0, 32'd0,        32'd0,     0, 0, 0, 0, 32'd0, 32'd0,     1, 7, 0, 32'h55);
    add(0, 0, 1, 32'hFFFFFC03, 2, 0, 32'd0,        32'd0,     1, 0, 1, 0, 32'd3, 32'd0,     0, 0, 0, 32'd0);
    add(0, 0, 0, 32'd0,        0, 0, 32'd0,        32'd0,     0, 0, 0, 0, 32'd0, 32'd0,     1, 2, 0, 32'd30);

    drive(1, 0, 0, 32'd0, 4'd0, 0, 32'd0, 32'd0);
    drive(1, 0, 0, 32'd0, 4'd0, 0, 32'd0, 32'd0);
    mem_init = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].flush, vecs[i].lv, vecs[i].la, vecs[i].lt,
            vecs[i].sv, vecs[i].sa, vecs[i].sd);
      chk($sformatf("v%0d ld_ready", i),   32'(bus.ld_req_ready),  32'(vecs[i].lr));
      chk($sformatf("v%0d st_ready", i),   32'(bus.st_req_ready),  32'(vecs[i].sr));
      chk($sformatf("v%0d rden", i),       32'(bus.dm_rden),       32'(vecs[i].rd));
      chk($sformatf("v%0d wren", i),       32'(bus.dm_wren),       32'(vecs[i].wr));
      chk($sformatf("v%0d address", i),    bus.dm_address,         vecs[i].addr);
      chk($sformatf("v%0d wdata", i),      bus.dm_data,            vecs[i].data);
      chk($sformatf("v%0d resp_valid", i), 32'(bus.ld_resp_valid), 32'(vecs[i].rv));
      if (vecs[i].rv || vecs[i].chk_rt)
        chk($sformatf("v%0d resp_tag", i), 32'(bus.ld_resp_tag),   32'(vecs[i].rt));
      if (vecs[i].rv)
        chk($sformatf("v%0d resp_data", i), bus.ld_resp_data,      vecs[i].rdata);
    end

    // Both requesters held high: four stores then one load, repeating.
    pat = "SSSSLSSSSLSS";
    prev_l = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drive(0, 0, 1, 32'd1, 4'd5, 1, 32'h10, 32'(i));
      exp_s = (pat[i] == "S");
      chk($sformatf("burst%0d st_ready", i), 32'(bus.st_req_ready), 32'(exp_s));
      chk($sformatf("burst%0d ld_ready", i), 32'(bus.ld_req_ready), 32'(!exp_s));
      chk($sformatf("burst%0d excl", i), 32'(bus.dm_rden && bus.dm_wren), 32'd0);
      chk($sformatf("burst%0d resp_valid", i), 32'(bus.ld_resp_valid), 32'(prev_l));
      if (prev_l) chk($sformatf("burst%0d resp_data", i), bus.ld_resp_data, 32'd10);
      prev_l = !exp_s;
    end

    // Reset with a partial streak, then the full four-store window must reappear.
    drive(1, 0, 1, 32'd1, 4'd5, 1, 32'h10, 32'd0);
    chk("rst ld_ready", 32'(bus.ld_req_ready), 32'd0);
    chk("rst st_ready", 32'(bus.st_req_ready), 32'd0);
    chk("rst rden", 32'(bus.dm_rden), 32'd0);
    chk("rst wren", 32'(bus.dm_wren), 32'd0);
    pat = "SSSSL";
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 32'd2, 4'd5, 1, 32'h10, 32'd0);
      exp_s = (pat[i] == "S");
      chk($sformatf("post_rst%0d st_ready", i), 32'(bus.st_req_ready), 32'(exp_s));
      chk($sformatf("post_rst%0d ld_ready", i), 32'(bus.ld_req_ready), 32'(!exp_s));
    end
    drive(0, 0, 0, 32'd0, 4'd0, 0, 32'd0, 32'd0);
    chk("post_rst resp_valid", 32'(bus.ld_resp_valid), 32'd1);
    chk("post_rst resp_tag", 32'(bus.ld_resp_tag), 32'd5);
    chk("post_rst resp_data", bus.ld_resp_data, 32'd20);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
